// File: rtl/apu_offload_queue.sv
// Issue buffer in front of the vector accelerator: a small instruction FIFO,
// a one-outstanding request FSM, and a held result for the scalar core.
module apu_offload_queue #(
   parameter int DEPTH      = 4,
   parameter int X_ID_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         n_reset,
   // core -> queue
   input  logic                         issue_valid_i,
   output logic                         issue_ready_o,
   input  logic [2:0][31:0]             issue_operands_i,
   input  logic [5:0]                   issue_op_i,
   input  logic [14:0]                  issue_flags_i,
   input  logic [X_ID_WIDTH-1:0]        issue_id_i,
   input  logic                         flush_i,
   // queue -> accelerator
   output logic                         apu_req_o,
   output logic [2:0][31:0]             apu_operands_o,
   output logic [5:0]                   apu_op_o,
   output logic [14:0]                  apu_flags_o,
   output logic [X_ID_WIDTH-1:0]        offloaded_id_o,
   input  logic                         apu_gnt_i,
   input  logic                         apu_rvalid_i,
   input  logic [31:0]                  apu_result_i,
   input  logic [X_ID_WIDTH-1:0]        instruction_id_i,
   // queue -> core
   output logic                         result_valid_o,
   input  logic                         result_ready_i,
   output logic [31:0]                  result_data_o,
   output logic [X_ID_WIDTH-1:0]        result_id_o,
   // status
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         error_o,
   output logic [1:0]                   state_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Handshakes: a transfer happens on a cycle where valid (or req) and
   // ready (or gnt) are both high at the rising edge; the producer holds its
   // payload stable from raising valid until the transfer, and the consumer's
   // ready never depends combinationally on the producer's valid.

   logic [2:0][31:0]        ops_mem   [DEPTH];
   logic [5:0]              op_mem    [DEPTH];
   logic [14:0]             flags_mem [DEPTH];
   logic [X_ID_WIDTH-1:0]   id_mem    [DEPTH];

   logic [PTR_W-1:0]        wr_ptr_q;
   logic [PTR_W-1:0]        rd_ptr_q;
   logic [CNT_W-1:0]        count_q;

   state_t                  state_q;
   state_t                  state_d;
   logic [X_ID_WIDTH-1:0]   exp_id_q;
   logic [31:0]             result_data_q;
   logic [X_ID_WIDTH-1:0]   result_id_q;
   logic                    error_q;

   logic                    head_valid;
   logic                    push;
   logic                    pop;
   logic                    capture;
   logic                    err_set;
   logic [X_ID_WIDTH-1:0]   cmp_id;

   assign head_valid    = (count_q != '0);
   assign issue_ready_o = (count_q != FULL_CNT);
   assign apu_req_o     = (state_q == S_IDLE) && head_valid;
   assign push          = issue_valid_i && issue_ready_o && !flush_i;
   assign pop           = apu_req_o && apu_gnt_i;

   // Head fields come straight from storage and read as zero when empty.
   assign apu_operands_o = head_valid ? ops_mem[rd_ptr_q]   : '0;
   assign apu_op_o       = head_valid ? op_mem[rd_ptr_q]    : '0;
   assign apu_flags_o    = head_valid ? flags_mem[rd_ptr_q] : '0;
   assign offloaded_id_o = head_valid ? id_mem[rd_ptr_q]    : '0;

   assign result_valid_o = (state_q == S_RESP);
   assign result_data_o  = result_data_q;
   assign result_id_o    = result_id_q;
   assign count_o        = count_q;
   assign error_o        = error_q;
   assign state_o        = state_q;

   always_ff @(posedge clk) begin
      if (push) begin
         ops_mem[wr_ptr_q]   <= issue_operands_i;
         op_mem[wr_ptr_q]    <= issue_op_i;
         flags_mem[wr_ptr_q] <= issue_flags_i;
         id_mem[wr_ptr_q]    <= issue_id_i;
      end
   end

   // Flush clears occupancy; a same-cycle grant has already consumed the head.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      err_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               if (apu_rvalid_i) begin
                  capture = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (apu_rvalid_i) begin
               err_set = 1'b1;
            end
         end
         S_WAIT: begin
            if (apu_rvalid_i) begin
               capture = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (apu_rvalid_i)   err_set = 1'b1;
            if (result_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A same-cycle response is checked against the entry being granted.
      cmp_id = (state_q == S_IDLE) ? offloaded_id_o : exp_id_q;
      if (capture && (instruction_id_i != cmp_id)) err_set = 1'b1;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q       <= S_IDLE;
         exp_id_q      <= '0;
         result_data_q <= '0;
         result_id_q   <= '0;
         error_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pop) exp_id_q <= offloaded_id_o;
         if (capture) begin
            result_data_q <= apu_result_i;
            result_id_q   <= instruction_id_i;
         end
         if (err_set) error_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_apu_offload_queue.sv
// Directed bench for apu_offload_queue: issue and result scoreboards, one
// linear sequence of steps, immediate assertions at every comparison.
module tb_apu_offload_queue;

   localparam int DEPTH = 4;
   localparam int XW    = 4;
   localparam int ISS_W = 96 + 6 + 15 + XW;
   localparam int RES_W = XW + 32;

   logic               clk = 1'b0;
   logic               n_reset = 1'b0;
   logic               issue_valid_i = 1'b0;
   logic               issue_ready_o;
   logic [2:0][31:0]   issue_operands_i = '0;
   logic [5:0]         issue_op_i = '0;
   logic [14:0]        issue_flags_i = '0;
   logic [XW-1:0]      issue_id_i = '0;
   logic               flush_i = 1'b0;
   logic               apu_req_o;
   logic [2:0][31:0]   apu_operands_o;
   logic [5:0]         apu_op_o;
   logic [14:0]        apu_flags_o;
   logic [XW-1:0]      offloaded_id_o;
   logic               apu_gnt_i = 1'b0;
   logic               apu_rvalid_i = 1'b0;
   logic [31:0]        apu_result_i = '0;
   logic [XW-1:0]      instruction_id_i = '0;
   logic               result_valid_o;
   logic               result_ready_i = 1'b0;
   logic [31:0]        result_data_o;
   logic [XW-1:0]      result_id_o;
   logic [2:0]         count_o;
   logic               error_o;
   logic [1:0]         state_o;

   int checks = 0;
   int errors = 0;
   int mdl_cnt = 0;
   logic [ISS_W-1:0] iss_q[$];
   logic [RES_W-1:0] exp_q[$];

   apu_offload_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(XW)) dut (
      .clk(clk), .n_reset(n_reset),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_operands_i(issue_operands_i), .issue_op_i(issue_op_i),
      .issue_flags_i(issue_flags_i), .issue_id_i(issue_id_i),
      .flush_i(flush_i),
      .apu_req_o(apu_req_o), .apu_operands_o(apu_operands_o),
      .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
      .offloaded_id_o(offloaded_id_o), .apu_gnt_i(apu_gnt_i),
      .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
      .instruction_id_i(instruction_id_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_data_o(result_data_o), .result_id_o(result_id_o),
      .count_o(count_o), .error_o(error_o), .state_o(state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks: inputs change right after the falling edge
   task automatic push_instr(input logic [5:0] op, input logic [XW-1:0] id,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      bit acc;
      logic [2:0][31:0] ops;
      logic [14:0] flags;
      acc = (mdl_cnt < DEPTH);
      check("issue_ready", issue_ready_o, acc);
      ops   = {a, b, c};
      flags = 15'($urandom_range(0, 32767));
      issue_valid_i    = 1'b1;
      issue_operands_i = ops;
      issue_op_i       = op;
      issue_flags_i    = flags;
      issue_id_i       = id;
      if (acc) begin
         iss_q.push_back({ops, op, flags, id});
         mdl_cnt++;
      end
      @(negedge clk);
      issue_valid_i = 1'b0;
   endtask

   task automatic drive_rvalid(input logic [31:0] res, input logic [XW-1:0] rid);
      apu_rvalid_i     = 1'b1;
      apu_result_i     = res;
      instruction_id_i = rid;
      @(negedge clk);
      apu_rvalid_i = 1'b0;
   endtask

   // rv_delay: 0 same-cycle rvalid, >0 cycles after grant, <0 caller drives it
   task automatic grant_one(input int rv_delay, input logic [31:0] res,
                            input logic [XW-1:0] rid, input bit with_flush);
      int n;
      logic [ISS_W-1:0] exp;
      n = 0;
      while (apu_req_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", apu_req_o, 1'b1);
      if (apu_req_o === 1'b1) begin
         exp = (iss_q.size() > 0) ? iss_q.pop_front() : '1;
         check("head_fields", {apu_operands_o, apu_op_o, apu_flags_o, offloaded_id_o}, exp);
         apu_gnt_i = 1'b1;
         flush_i   = with_flush;
         if (rv_delay == 0) begin
            apu_rvalid_i     = 1'b1;
            apu_result_i     = res;
            instruction_id_i = rid;
         end
         exp_q.push_back({rid, res});
         @(negedge clk);
         apu_gnt_i    = 1'b0;
         flush_i      = 1'b0;
         apu_rvalid_i = 1'b0;
         if (with_flush) begin
            mdl_cnt = 0;
            iss_q.delete();
         end else begin
            mdl_cnt--;
         end
         if (rv_delay > 0) begin
            for (int i = 1; i < rv_delay; i++) begin
               check("req_low_wait", apu_req_o, 1'b0);
               @(negedge clk);
            end
            drive_rvalid(res, rid);
         end
      end
   endtask

   task automatic take_result();
      int n;
      logic [RES_W-1:0] exp;
      n = 0;
      while (result_valid_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("result_seen", result_valid_o, 1'b1);
      if (result_valid_o === 1'b1) begin
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         check("result_id_data", {result_id_o, result_data_o}, exp);
         result_ready_i = 1'b1;
         @(negedge clk);
         result_ready_i = 1'b0;
         check("result_released", result_valid_o, 1'b0);
      end
   endtask

   initial begin
      logic [ISS_W-1:0] head;
      logic [RES_W-1:0] rexp;

      // reset
      repeat (3) @(negedge clk);
      n_reset = 1'b1;
      check("rst_req", apu_req_o, 1'b0);
      check("rst_ready", issue_ready_o, 1'b1);
      check("rst_count", count_o, 3'd0);
      check("rst_result", {result_valid_o, result_data_o, result_id_o}, '0);
      check("rst_error", error_o, 1'b0);
      check("rst_head", {apu_operands_o, apu_op_o, apu_flags_o, offloaded_id_o}, '0);
      check("rst_state", state_o, 2'd0);

      // single instruction, rvalid two cycles after grant
      push_instr(6'h05, 4'd3, 32'd1, 32'd2, 32'd3);
      check("single_req", apu_req_o, 1'b1);
      check("single_count", count_o, 3'd1);
      grant_one(2, 32'h10, 4'd3, 1'b0);
      check("single_state", state_o, 2'd2);
      take_result();
      check("single_err", error_o, 1'b0);

      // fill with grant held low; fifth push is dropped
      for (int i = 0; i < 5; i++)
         push_instr(6'($urandom_range(0, 63)), XW'(i), $urandom, $urandom, $urandom);
      check("full_count", count_o, 3'd4);
      check("full_ready", issue_ready_o, 1'b0);
      for (int i = 0; i < 4; i++) begin
         grant_one(1, 32'h100 + 32'(i), XW'(i), 1'b0);
         take_result();
      end
      check("drain_count", count_o, 3'd0);
      check("drain_req", apu_req_o, 1'b0);

      // back-to-back: same-cycle grant/rvalid, result_ready held high
      for (int i = 0; i < 4; i++)
         push_instr(6'($urandom_range(0, 63)), XW'(8 + i), $urandom, $urandom, $urandom);
      result_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         check("tp_req", apu_req_o, (c % 2 == 0));
         if (c % 2 == 0) begin
            head = (iss_q.size() > 0) ? iss_q.pop_front() : '1;
            check("tp_head", {apu_operands_o, apu_op_o, apu_flags_o, offloaded_id_o}, head);
            apu_gnt_i        = 1'b1;
            apu_rvalid_i     = 1'b1;
            apu_result_i     = 32'hA000 + 32'(c);
            instruction_id_i = head[XW-1:0];
            exp_q.push_back({head[XW-1:0], 32'hA000 + 32'(c)});
            mdl_cnt--;
         end else begin
            check("tp_valid", result_valid_o, 1'b1);
            rexp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("tp_result", {result_id_o, result_data_o}, rexp);
            apu_gnt_i    = 1'b0;
            apu_rvalid_i = 1'b0;
         end
         @(negedge clk);
      end
      result_ready_i = 1'b0;
      check("tp_done", {result_valid_o, apu_req_o, count_o}, '0);

      // flush in S_WAIT with three queued entries, plus a dropped push
      for (int i = 0; i < 4; i++)
         push_instr(6'h11, XW'(i), $urandom, $urandom, $urandom);
      grant_one(-1, 32'hBEEF, 4'd0, 1'b0);
      check("flush_pre_count", count_o, 3'd3);
      flush_i       = 1'b1;
      issue_valid_i = 1'b1;
      issue_id_i    = 4'd9;
      @(negedge clk);
      flush_i       = 1'b0;
      issue_valid_i = 1'b0;
      mdl_cnt = 0;
      iss_q.delete();
      check("flush_count", count_o, 3'd0);
      check("flush_state", state_o, 2'd1);
      drive_rvalid(32'hBEEF, 4'd0);
      take_result();
      for (int i = 0; i < 3; i++) begin
         check("flush_no_req", apu_req_o, 1'b0);
         @(negedge clk);
      end
      check("flush_err", error_o, 1'b0);

      // flush with same-cycle grant: granted entry still completes
      push_instr(6'h21, 4'd4, 32'd7, 32'd8, 32'd9);
      push_instr(6'h22, 4'd5, 32'd1, 32'd1, 32'd1);
      grant_one(0, 32'hC0DE, 4'd4, 1'b1);
      check("fg_count", count_o, 3'd0);
      take_result();
      check("fg_err", error_o, 1'b0);
      check("fg_no_req", apu_req_o, 1'b0);

      // ID mismatch: error is sticky across a later good transaction
      push_instr(6'h05, 4'd2, 32'd4, 32'd5, 32'd6);
      grant_one(1, 32'h55, 4'd5, 1'b0);
      check("mm_err", error_o, 1'b1);
      take_result();
      push_instr(6'h06, 4'd7, 32'd4, 32'd5, 32'd6);
      grant_one(0, 32'h66, 4'd7, 1'b0);
      take_result();
      check("mm_sticky", error_o, 1'b1);

      // async reset while in S_RESP with an entry still queued
      push_instr(6'h07, 4'd1, 32'd1, 32'd2, 32'd3);
      push_instr(6'h08, 4'd2, 32'd1, 32'd2, 32'd3);
      grant_one(0, 32'h77, 4'd1, 1'b0);
      check("ar_pre_valid", result_valid_o, 1'b1);
      check("ar_pre_count", count_o, 3'd1);
      #2 n_reset = 1'b0;
      #1;
      check("ar_valid", result_valid_o, 1'b0);
      check("ar_count", count_o, 3'd0);
      check("ar_req", apu_req_o, 1'b0);
      check("ar_err", error_o, 1'b0);
      check("ar_ready", issue_ready_o, 1'b1);
      check("ar_data", result_data_o, 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      mdl_cnt = 0;
      iss_q.delete();
      exp_q.delete();

      // stray rvalid in S_IDLE without a grant
      check("stray_pre", error_o, 1'b0);
      drive_rvalid(32'h1, 4'd1);
      check("stray_err", error_o, 1'b1);
      check("stray_state", state_o, 2'd0);

      check("iss_q_empty", iss_q.size(), 0);
      check("exp_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
